msl_sel_seq: RTL and testbench

Sequencer for the 6-element mismatch-shaping loop. It accepts one DAC code per sample over a valid/ready handshake and snapshots the six loop-filter outputs. It then builds the 6-bit element-select vector serially, picking one largest-SFM element per cycle. Finally it commits the vector to the loop filter with a one-cycle `filt_en` strobe and, on filter overload, holds the filter in reset for a programmable flush.

---
 rtl/msl_sel_seq_if.sv | 29 ++
 rtl/msl_sel_seq.sv | 149 ++++++++++++++
 tb/tb_msl_sel_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/msl_sel_seq_if.sv
// Handshake and loop-filter bus of the mismatch-shaping select sequencer.
// The producer/filter side uses the master modport; the sequencer uses the slave modport.
interface msl_sel_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic [5:0] sfm0;
  logic [5:0] sfm1;
  logic [5:0] sfm2;
  logic [5:0] sfm3;
  logic [5:0] sfm4;
  logic [5:0] sfm5;
  logic [5:0] sv;
  logic       filt_en;
  logic       sv_valid;
  logic       filt_rstn;
  logic       busy;
  logic [7:0] ovl_cnt;

  modport master (
    output in_valid, in_code, sfm0, sfm1, sfm2, sfm3, sfm4, sfm5,
    input  in_ready, sv, filt_en, sv_valid, filt_rstn, busy, ovl_cnt
  );

  modport slave (
    input  in_valid, in_code, sfm0, sfm1, sfm2, sfm3, sfm4, sfm5,
    output in_ready, sv, filt_en, sv_valid, filt_rstn, busy, ovl_cnt
  );
endinterface

// File: rtl/msl_sel_seq.sv
// Element-select sequencer for the 6-element mismatch-shaping loop.
// Overload detection and loop-filter flush are built only when MSL_OVL_FLUSH_EN is defined.
//
// state  | meaning
// IDLE   | ready for a DAC code; snapshot SFMs on acceptance
// SEL    | pick one largest unselected element per cycle
// COMMIT | drive sv and pulse filt_en for one cycle
// FLUSH  | hold loop filter in reset for FLUSH_LEN cycles
module msl_sel_seq #(
  parameter int OVL_THR   = 40,
  parameter int FLUSH_LEN = 4
) (
  input  logic         clk,
  input  logic         rstn,
  msl_sel_seq_if.slave bus
);

  if (FLUSH_LEN < 1 || FLUSH_LEN > 15 || OVL_THR < 0 || OVL_THR > 63) begin : g_bad_param
    $error("msl_sel_seq: FLUSH_LEN must be 1..15 and OVL_THR 0..63");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEL    = 2'd1,
    S_COMMIT = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  localparam logic [3:0] L_FLUSH_M1 = 4'(FLUSH_LEN - 1);

  state_t     r_state;
  logic [5:0] r_snap [6];
  logic [5:0] r_acc;
  logic [2:0] r_rem;
  logic       r_ovl;
  logic [5:0] r_sv;
  logic       r_filt_en;
  logic       r_filt_rstn;
  logic [3:0] r_flush_cnt;
  logic [7:0] r_ovl_cnt;

  logic [5:0] w_sfm_in [6];
  logic [2:0] w_code;
  logic       w_ovl;
  logic [5:0] w_pick_oh;
  logic [5:0] w_best;
  logic       w_found;

  assign w_sfm_in[0] = bus.sfm0;
  assign w_sfm_in[1] = bus.sfm1;
  assign w_sfm_in[2] = bus.sfm2;
  assign w_sfm_in[3] = bus.sfm3;
  assign w_sfm_in[4] = bus.sfm4;
  assign w_sfm_in[5] = bus.sfm5;

  assign w_code = (bus.in_code == 3'd7) ? 3'd6 : bus.in_code;

`ifdef MSL_OVL_FLUSH_EN
  localparam logic [5:0] L_OVL_THR = 6'(OVL_THR);

  always_comb begin
    w_ovl = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (w_sfm_in[i] >= L_OVL_THR) w_ovl = 1'b1;
    end
  end
`else
  assign w_ovl = 1'b0;
`endif

  // Strict '>' while scanning upward keeps ties on the lowest index.
  always_comb begin
    w_pick_oh = '0;
    w_best    = '0;
    w_found   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!r_acc[i] && (!w_found || r_snap[i] > w_best)) begin
        w_found      = 1'b1;
        w_best       = r_snap[i];
        w_pick_oh    = '0;
        w_pick_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_snap      <= '{default: 6'd0};
      r_acc       <= '0;
      r_rem       <= '0;
      r_ovl       <= 1'b0;
      r_sv        <= '0;
      r_filt_en   <= 1'b0;
      r_filt_rstn <= 1'b0;
      r_flush_cnt <= '0;
      r_ovl_cnt   <= '0;
    end else begin
      r_filt_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_filt_rstn <= 1'b1;
          if (bus.in_valid) begin
            r_snap  <= w_sfm_in;
            r_acc   <= '0;
            r_rem   <= w_code;
            r_ovl   <= w_ovl;
            r_state <= (w_code != 3'd0) ? S_SEL : S_COMMIT;
          end
        end
        S_SEL: begin
          r_acc <= r_acc | w_pick_oh;
          r_rem <= r_rem - 3'd1;
          if (r_rem == 3'd1) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_sv      <= r_acc;
          r_filt_en <= 1'b1;
          if (r_ovl) begin
            r_state     <= S_FLUSH;
            r_filt_rstn <= 1'b0;
            r_flush_cnt <= L_FLUSH_M1;
            if (r_ovl_cnt != 8'hFF) r_ovl_cnt <= r_ovl_cnt + 8'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            r_filt_rstn <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rstn & (r_state == S_IDLE);
  assign bus.sv        = r_sv;
  assign bus.filt_en   = r_filt_en;
  assign bus.sv_valid  = r_filt_en;
  assign bus.filt_rstn = r_filt_rstn;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.ovl_cnt   = r_ovl_cnt;

endmodule

// File: tb/tb_msl_sel_seq.sv
// Directed bench for msl_sel_seq: expected select vectors are queued at acceptance
// and compared when filt_en strobes. Overload expectations follow MSL_OVL_FLUSH_EN.
module tb_msl_sel_seq;

  typedef struct {
    logic [5:0] sv;
    logic       ovl;
    int         e0;
    int         k;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         exp_ovl_cnt = 0;
  int         last_e0 = 0;
  int         last_commit = 0;
  logic [5:0] sfm_drv [6];
  exp_t       sb [$];

  msl_sel_seq_if u_if();

  msl_sel_seq #(.OVL_THR(40), .FLUSH_LEN(4)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_sfm();
    u_if.sfm0 = sfm_drv[0];
    u_if.sfm1 = sfm_drv[1];
    u_if.sfm2 = sfm_drv[2];
    u_if.sfm3 = sfm_drv[3];
    u_if.sfm4 = sfm_drv[4];
    u_if.sfm5 = sfm_drv[5];
  endtask

  task automatic set_sfm(input int a0, input int a1, input int a2, input int a3, input int a4, input int a5);
    sfm_drv[0] = 6'(a0); sfm_drv[1] = 6'(a1); sfm_drv[2] = 6'(a2);
    sfm_drv[3] = 6'(a3); sfm_drv[4] = 6'(a4); sfm_drv[5] = 6'(a5);
    drive_sfm();
  endtask

  // Element i is chosen when fewer than k elements outrank it (larger value, or equal with lower index).
  function automatic logic [5:0] model_sv(input int k);
    logic [5:0] v;
    int rank;
    v = '0;
    for (int i = 0; i < 6; i++) begin
      rank = 0;
      for (int j = 0; j < 6; j++) begin
        if (sfm_drv[j] > sfm_drv[i] || (sfm_drv[j] == sfm_drv[i] && j < i)) rank++;
      end
      v[i] = (rank < k);
    end
    return v;
  endfunction

  task automatic send(input logic [2:0] code, input bit hold);
    exp_t e;
    int n;
    n = 0;
    u_if.in_code  = code;
    drive_sfm();
    u_if.in_valid = 1'b1;
    e.k  = (code == 3'd7) ? 6 : int'(code);
    e.sv = model_sv(e.k);
    e.ovl = 1'b0;
`ifdef MSL_OVL_FLUSH_EN
    for (int i = 0; i < 6; i++) if (sfm_drv[i] >= 6'd40) e.ovl = 1'b1;
`endif
    while (u_if.in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (u_if.in_ready !== 1'b1) begin
      chk("accept_timeout", u_if.in_ready, 1);
      u_if.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    e.e0    = cyc;
    last_e0 = cyc;
    if (!hold) u_if.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) sfm_drv[i] = 6'($urandom_range(63, 0));
    drive_sfm();
    sb.push_back(e);
  endtask

  task automatic expect_commit(input string tag);
    exp_t e;
    int n;
    int rdy_hi;
    int fe_hi;
    n = 0; rdy_hi = 0; fe_hi = 0;
    while (u_if.filt_en !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (u_if.filt_en !== 1'b1) begin
      chk({tag, "_filt_en_timeout"}, u_if.filt_en, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_filt_en"}, u_if.filt_en, 0);
      return;
    end
    e = sb.pop_front();
    last_commit = cyc;
    if (e.ovl && exp_ovl_cnt < 255) exp_ovl_cnt++;
    chk({tag, "_sv"}, u_if.sv, e.sv);
    chk({tag, "_sv_valid"}, u_if.sv_valid, 1);
    chk({tag, "_latency"}, cyc, e.e0 + e.k + 1);
    chk({tag, "_popcount"}, $countones(u_if.sv), e.k);
    chk({tag, "_ovl_cnt"}, u_if.ovl_cnt, exp_ovl_cnt);
    if (e.ovl) begin
      n = 0;
      while (u_if.filt_rstn === 1'b0 && n < 20) begin
        if (u_if.in_ready !== 1'b0) rdy_hi++;
        if (n > 0 && u_if.filt_en !== 1'b0) fe_hi++;
        n++;
        @(negedge clk);
      end
      chk({tag, "_flush_len"}, n, 4);
      chk({tag, "_ready_in_flush"}, rdy_hi, 0);
      chk({tag, "_filt_en_in_flush"}, fe_hi, 0);
      chk({tag, "_ready_after_flush"}, u_if.in_ready, 1);
    end else begin
      chk({tag, "_filt_rstn"}, u_if.filt_rstn, 1);
      chk({tag, "_ready_at_commit"}, u_if.in_ready, 1);
      if (u_if.in_valid !== 1'b1) begin
        @(negedge clk);
        chk({tag, "_filt_en_one_cycle"}, u_if.filt_en, 0);
      end
    end
  endtask

  initial begin
    int n_fe;
    int n_sat;
    rstn          = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_code  = 3'd0;
    set_sfm(0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", u_if.in_ready, 0);
    chk("rst_sv", u_if.sv, 0);
    chk("rst_filt_en", u_if.filt_en, 0);
    chk("rst_sv_valid", u_if.sv_valid, 0);
    chk("rst_filt_rstn", u_if.filt_rstn, 0);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_ovl_cnt", u_if.ovl_cnt, 0);
    rstn = 1'b1;
    #1;
    chk("rel_in_ready", u_if.in_ready, 1);
    chk("rel_filt_rstn_before_edge", u_if.filt_rstn, 0);
    @(negedge clk);
    chk("rel_filt_rstn_after_edge", u_if.filt_rstn, 1);

    // sfm0..5 = 10,3,25,7,25,1 with code 2 picks elements 2 and 4
    set_sfm(10, 3, 25, 7, 25, 1);
    send(3'd2, 1'b0);
    expect_commit("t1");
    chk("t1_sv_literal", u_if.sv, 6'b010100);

    set_sfm(33, 12, 5, 39, 0, 17);
    send(3'd0, 1'b0);
    expect_commit("code0");

    set_sfm(1, 2, 3, 4, 5, 6);
    send(3'd7, 1'b0);
    expect_commit("code7");
    chk("code7_sv_literal", u_if.sv, 6'b111111);

    set_sfm(8, 30, 30, 2, 19, 11);
    send(3'd3, 1'b1);
    set_sfm(4, 4, 9, 9, 1, 0);
    u_if.in_code = 3'd1;
    expect_commit("b2b_a");
    send(3'd1, 1'b0);
    chk("b2b_accept_cycle", last_e0, last_commit + 1);
    expect_commit("b2b_b");

    set_sfm(5, 9, 45, 12, 3, 20);
    send(3'd1, 1'b0);
    expect_commit("ovl");
    chk("ovl_sv_literal", u_if.sv, 6'b000100);
`ifdef MSL_OVL_FLUSH_EN
    chk("ovl_cnt_after_first", u_if.ovl_cnt, 1);
`else
    chk("ovl_cnt_disabled", u_if.ovl_cnt, 0);
`endif

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 6; i++) sfm_drv[i] = 6'($urandom_range(63, 0));
      send(3'($urandom_range(7, 0)), 1'b0);
      expect_commit("rand");
    end

    set_sfm(20, 21, 22, 23, 24, 25);
    send(3'd5, 1'b0);
    chk("sel_busy", u_if.busy, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready", u_if.in_ready, 0);
    chk("mid_rst_sv", u_if.sv, 0);
    chk("mid_rst_filt_en", u_if.filt_en, 0);
    chk("mid_rst_sv_valid", u_if.sv_valid, 0);
    chk("mid_rst_filt_rstn", u_if.filt_rstn, 0);
    chk("mid_rst_busy", u_if.busy, 0);
    chk("mid_rst_ovl_cnt", u_if.ovl_cnt, 0);
    sb.delete();
    exp_ovl_cnt = 0;
    @(negedge clk);
    rstn = 1'b1;
    n_fe = 0;
    repeat (12) begin
      @(negedge clk);
      if (u_if.filt_en === 1'b1) n_fe++;
    end
    chk("mid_rst_no_filt_en", n_fe, 0);
    chk("mid_rst_filt_rstn_back", u_if.filt_rstn, 1);
    set_sfm(3, 50 - 20, 7, 7, 31, 2);
    send(3'd2, 1'b0);
    expect_commit("post_rst");

`ifdef MSL_OVL_FLUSH_EN
    n_sat = 300;
`else
    n_sat = 20;
`endif
    for (int s = 0; s < n_sat; s++) begin
      set_sfm(63, 40, 0, 12, 41, 9);
      send(3'd0, 1'b0);
      expect_commit("sat");
    end
`ifdef MSL_OVL_FLUSH_EN
    chk("ovl_cnt_saturated", u_if.ovl_cnt, 255);
`else
    chk("ovl_cnt_stays_zero", u_if.ovl_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
